// File: rtl/spad_feature_loader.sv
// rtl/spad_feature_loader.sv - feature RAM to scratchpad line loader
//
// Purpose: on start, reads N feature rows (N = 5, 3 or 1 by mode) of
// row_words 128-bit words each from the feature RAM, and writes every word
// into the scratchpad, tagged with its line number, under group_full
// backpressure. Completion is signalled with a one-cycle done pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a load (accepted only in IDLE)
//   kn_size_mode       line-count select, latched at start
//   base_addr          RAM address of line 0 word 0, latched at start
//   row_words          words per line, latched at start
//   row_stride         RAM address distance between lines, latched at start
//   busy, done         load in progress / one-cycle completion pulse
//   ram_rd_en          RAM read strobe
//   ram_addr           RAM read address
//   ram_rd_data        RAM read data, valid one cycle after ram_rd_en
//   wr_mem_line        scratchpad target line of the current write
//   spad_data          scratchpad write data
//   wr_en              scratchpad write strobe
//   group_full         scratchpad full; blocks reads and writes
module spad_feature_loader #(
  parameter int         KERNEL_SIZE        = 5,
  parameter int         DATA_BUS_WIDTH     = 128,
  parameter int         ADDR_W             = 12,
  parameter logic [1:0] KERNEL_SIZE_5_MODE = 2'd0,
  parameter logic [1:0] KERNEL_SIZE_3_MODE = 2'd1,
  parameter logic [1:0] KERNEL_SIZE_1_MODE = 2'd2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                kn_size_mode,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [7:0]                row_words,
  input  logic [ADDR_W-1:0]         row_stride,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [DATA_BUS_WIDTH-1:0] ram_rd_data,
  output logic [3:0]                wr_mem_line,
  output logic [DATA_BUS_WIDTH-1:0] spad_data,
  output logic                      wr_en,
  input  logic                      group_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched load configuration
  logic [3:0]        n_lines_q, n_lines_d;
  logic [7:0]        row_words_q, row_words_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  // Issue position; line_addr_q holds base + line*stride
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [3:0]        line_q, line_d;
  logic [7:0]        word_q, word_d;

  // One read in flight (issued last cycle) and its line tag
  logic              inflight_q, inflight_d;
  logic [3:0]        inflight_tag_q, inflight_tag_d;

  // Two-entry holding FIFO between RAM return and scratchpad write
  logic [DATA_BUS_WIDTH-1:0] hold_data_q [2];
  logic [DATA_BUS_WIDTH-1:0] hold_data_d [2];
  logic [3:0]                hold_tag_q [2];
  logic [3:0]                hold_tag_d [2];
  logic                      hold_wr_ptr_q, hold_wr_ptr_d;
  logic                      hold_rd_ptr_q, hold_rd_ptr_d;
  logic [1:0]                hold_cnt_q, hold_cnt_d;

  logic       hold_empty;
  logic       push;
  logic       pop;
  logic       last_word;
  logic       last_line;
  logic [2:0] occ_eff;

  always_comb begin
    state_d        = state_q;
    n_lines_d      = n_lines_q;
    row_words_d    = row_words_q;
    stride_d       = stride_q;
    line_addr_d    = line_addr_q;
    line_d         = line_q;
    word_d         = word_q;
    hold_data_d    = hold_data_q;
    hold_tag_d     = hold_tag_q;
    hold_wr_ptr_d  = hold_wr_ptr_q;
    hold_rd_ptr_d  = hold_rd_ptr_q;

    hold_empty = (hold_cnt_q == 2'd0);
    wr_en      = !hold_empty && !group_full;
    pop        = wr_en;
    push       = inflight_q;

    // Occupancy the buffer will have once this cycle's pop and the in-flight
    // word have settled; counting the pop keeps reads streaming at one per
    // cycle while still bounding outstanding words to two.
    occ_eff   = 3'(hold_cnt_q) + 3'(inflight_q) - 3'(pop);
    ram_rd_en = (state_q == S_ISSUE) && !group_full && (occ_eff < 3'd2);
    ram_addr  = (state_q == S_ISSUE) ? (line_addr_q + ADDR_W'(word_q)) : '0;

    wr_mem_line = hold_empty ? 4'd0 : hold_tag_q[hold_rd_ptr_q];
    spad_data   = hold_empty ? '0   : hold_data_q[hold_rd_ptr_q];

    busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);

    last_word = (word_q == row_words_q - 8'd1);
    last_line = (line_q == n_lines_q - 4'd1);

    inflight_d     = ram_rd_en;
    inflight_tag_d = line_q;

    if (push) begin
      hold_data_d[hold_wr_ptr_q] = ram_rd_data;
      hold_tag_d[hold_wr_ptr_q]  = inflight_tag_q;
      hold_wr_ptr_d              = ~hold_wr_ptr_q;
    end
    if (pop) begin
      hold_rd_ptr_d = ~hold_rd_ptr_q;
    end
    hold_cnt_d = hold_cnt_q + 2'(push) - 2'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kn_size_mode == KERNEL_SIZE_3_MODE) begin
            n_lines_d = 4'd3;
          end else if (kn_size_mode == KERNEL_SIZE_1_MODE) begin
            n_lines_d = 4'd1;
          end else if (kn_size_mode == KERNEL_SIZE_5_MODE) begin
            n_lines_d = 4'(KERNEL_SIZE);
          end else begin
            n_lines_d = 4'(KERNEL_SIZE);
          end
          row_words_d = row_words;
          stride_d    = row_stride;
          line_addr_d = base_addr;
          line_d      = 4'd0;
          word_d      = 8'd0;
          // An empty load passes through DRAIN (already empty) so busy is
          // shown for one cycle before the done pulse.
          state_d     = (row_words == 8'd0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ram_rd_en) begin
          if (last_word) begin
            word_d      = 8'd0;
            line_d      = line_q + 4'd1;
            line_addr_d = line_addr_q + stride_q;
            if (last_line) begin
              state_d = S_DRAIN;
            end
          end else begin
            word_d = word_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final word is written so done follows it directly.
        if (!inflight_q && ((hold_cnt_q == 2'd0) || ((hold_cnt_q == 2'd1) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      n_lines_q      <= 4'd0;
      row_words_q    <= 8'd0;
      stride_q       <= '0;
      line_addr_q    <= '0;
      line_q         <= 4'd0;
      word_q         <= 8'd0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= 4'd0;
      hold_wr_ptr_q  <= 1'b0;
      hold_rd_ptr_q  <= 1'b0;
      hold_cnt_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      n_lines_q      <= n_lines_d;
      row_words_q    <= row_words_d;
      stride_q       <= stride_d;
      line_addr_q    <= line_addr_d;
      line_q         <= line_d;
      word_q         <= word_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      hold_wr_ptr_q  <= hold_wr_ptr_d;
      hold_rd_ptr_q  <= hold_rd_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_tag_q  <= hold_tag_d;
  end

endmodule
